// File: rtl/pe_cmd_seq.sv
// -----------------------------------------------------------------------------
// pe_cmd_seq
//
// Command-issuing master for one floating-point MAC PE. It accepts a
// dot-product job (length K, optional preload value) and drives the PE command
// bus with:
//   RESET, SET_CONV_MODE(param_1=K), [LOAD_DATA], then K TRIGGER/TRIGGER_LAST
//   beats fed from the operand stream.
// It then waits for the PE busy flag to clear, or for a timeout, and returns
// the PE accumulator on a valid/ready result port.
//
// Optional build macro:
//   PE_CMD_SEQ_FORWARD_EN - after the last trigger beat, issue FLUSH_CNT
//                           FORWARD commands (data/weight = 0) to drain
//                           downstream PEs before waiting on busy.
//
// Ports:
//   clk_i, rst_i         clock, asynchronous active-low reset
//   job_valid/job_ready  job handshake (ready only in IDLE)
//   job_len              K, number of MAC terms
//   job_preload(_val)    issue LOAD_DATA with this value before streaming
//   op_valid/op_ready    operand pair handshake
//   op_data, op_weight   activation / weight
//   pe_cmd_valid, pe_cmd registered one-cycle command strobe and code
//   pe_param_1           param_1 to PE (K on SET_CONV_MODE)
//   pe_preload_data      preload value to PE (LOAD_DATA)
//   pe_data, pe_weight   operands to PE (TRIGGER / FORWARD)
//   pe_busy              PE busy flag
//   pe_mac_value         PE accumulator
//   res_valid/res_ready  result handshake
//   res_data, res_err    captured accumulator, timeout flag
// -----------------------------------------------------------------------------
module pe_cmd_seq #(
  parameter int ACLEN      = 8,
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int TIMEOUT    = 1024,
  parameter int FLUSH_CNT  = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  job_valid,
  output logic                  job_ready,
  input  logic [LEN_WIDTH-1:0]  job_len,
  input  logic                  job_preload,
  input  logic [DATA_WIDTH-1:0] job_preload_val,
  input  logic                  op_valid,
  output logic                  op_ready,
  input  logic [DATA_WIDTH-1:0] op_data,
  input  logic [DATA_WIDTH-1:0] op_weight,
  output logic                  pe_cmd_valid,
  output logic [ACLEN:0]        pe_cmd,
  output logic [DATA_WIDTH-1:0] pe_param_1,
  output logic [DATA_WIDTH-1:0] pe_preload_data,
  output logic [DATA_WIDTH-1:0] pe_data,
  output logic [DATA_WIDTH-1:0] pe_weight,
  input  logic                  pe_busy,
  input  logic [DATA_WIDTH-1:0] pe_mac_value,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [DATA_WIDTH-1:0] res_data,
  output logic                  res_err
);

  localparam int CW    = ACLEN + 1;
  localparam int TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CLR  = 3'd1;
  localparam logic [2:0] S_CFG  = 3'd2;
  localparam logic [2:0] S_PRE  = 3'd3;
  localparam logic [2:0] S_STRM = 3'd4;
  localparam logic [2:0] S_WAIT = 3'd5;
  localparam logic [2:0] S_RES  = 3'd6;

  localparam logic [CW-1:0] CMD_RESET    = CW'(0);
  localparam logic [CW-1:0] CMD_TRIGGER  = CW'(1);
  localparam logic [CW-1:0] CMD_TRIG_LST = CW'(2);
  localparam logic [CW-1:0] CMD_LOAD     = CW'(5);
  localparam logic [CW-1:0] CMD_CONV     = CW'(6);

`ifdef PE_CMD_SEQ_FORWARD_EN
  localparam logic [2:0]    S_FLSH      = 3'd7;
  localparam logic [CW-1:0] CMD_FORWARD = CW'(8);
  localparam int            FL_W        = (FLUSH_CNT > 1) ? $clog2(FLUSH_CNT) : 1;
  logic [FL_W-1:0]          flush_cnt;
`else
  // FLUSH_CNT only matters when FORWARD draining is compiled in.
  if (FLUSH_CNT < 0) begin : g_flush_cnt_unused
  end
`endif

  logic [2:0]            state;
  logic [LEN_WIDTH-1:0]  len_q;
  logic                  pre_q;
  logic [DATA_WIDTH-1:0] pre_val_q;
  logic [LEN_WIDTH-1:0]  beat_cnt;
  logic [TMO_W-1:0]      tmo_cnt;
  logic                  seen_busy;
  logic                  op_fire;
  logic                  last_beat;

  logic                  cmd_vld_p1;
  logic [CW-1:0]         cmd_p1;
  logic [DATA_WIDTH-1:0] param_p1;
  logic [DATA_WIDTH-1:0] preload_p1;
  logic [DATA_WIDTH-1:0] data_p1;
  logic [DATA_WIDTH-1:0] weight_p1;
  logic [DATA_WIDTH-1:0] res_data_q;
  logic                  res_err_q;

  assign job_ready = (state == S_IDLE);
  // beat_cnt never exceeds len_q-1 while in STRM, so K=2^LEN_WIDTH-1 cannot wrap.
  assign op_ready  = (state == S_STRM) && (beat_cnt < len_q);
  assign op_fire   = op_valid && op_ready;
  assign last_beat = (beat_cnt == len_q - LEN_WIDTH'(1));

  // Job fields are plain data captured at acceptance; they are only read after.
  always_ff @(posedge clk_i) begin
    if (state == S_IDLE && job_valid) begin
      len_q     <= job_len;
      pre_q     <= job_preload;
      pre_val_q <= job_preload_val;
    end
  end

  // ---- stage p1: state machine and registered PE command bus ----
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= S_IDLE;
      beat_cnt   <= '0;
      tmo_cnt    <= '0;
      seen_busy  <= 1'b0;
      cmd_vld_p1 <= 1'b0;
      cmd_p1     <= '0;
      param_p1   <= '0;
      preload_p1 <= '0;
      data_p1    <= '0;
      weight_p1  <= '0;
      res_data_q <= '0;
      res_err_q  <= 1'b0;
`ifdef PE_CMD_SEQ_FORWARD_EN
      flush_cnt  <= '0;
`endif
    end else begin
      cmd_vld_p1 <= 1'b0;
      case (state)
        S_IDLE: begin
          if (job_valid) begin
            beat_cnt  <= '0;
            tmo_cnt   <= '0;
            seen_busy <= 1'b0;
            state     <= S_CLR;
          end
        end
        S_CLR: begin
          cmd_vld_p1 <= 1'b1;
          cmd_p1     <= CMD_RESET;
          state      <= S_CFG;
        end
        S_CFG: begin
          cmd_vld_p1 <= 1'b1;
          cmd_p1     <= CMD_CONV;
          param_p1   <= DATA_WIDTH'(len_q);
          if (len_q == '0) begin
            // Empty job: nothing to accumulate, report a clean zero.
            res_data_q <= '0;
            res_err_q  <= 1'b0;
            state      <= S_RES;
          end else if (pre_q) begin
            state <= S_PRE;
          end else begin
            state <= S_STRM;
          end
        end
        S_PRE: begin
          cmd_vld_p1 <= 1'b1;
          cmd_p1     <= CMD_LOAD;
          preload_p1 <= pre_val_q;
          state      <= S_STRM;
        end
        S_STRM: begin
          // Busy rises one cycle after the first trigger, often still in STRM.
          if (pe_busy) seen_busy <= 1'b1;
          if (op_fire) begin
            cmd_vld_p1 <= 1'b1;
            data_p1    <= op_data;
            weight_p1  <= op_weight;
            beat_cnt   <= beat_cnt + LEN_WIDTH'(1);
            // A lone TRIGGER_LAST would never raise busy, so K=1 uses TRIGGER.
            cmd_p1     <= (last_beat && len_q != LEN_WIDTH'(1)) ? CMD_TRIG_LST
                                                                 : CMD_TRIGGER;
            if (last_beat) begin
              tmo_cnt <= '0;
`ifdef PE_CMD_SEQ_FORWARD_EN
              flush_cnt <= '0;
              state     <= S_FLSH;
`else
              state     <= S_WAIT;
`endif
            end
          end
        end
`ifdef PE_CMD_SEQ_FORWARD_EN
        S_FLSH: begin
          if (pe_busy) seen_busy <= 1'b1;
          cmd_vld_p1 <= 1'b1;
          cmd_p1     <= CMD_FORWARD;
          data_p1    <= '0;
          weight_p1  <= '0;
          flush_cnt  <= flush_cnt + FL_W'(1);
          if (flush_cnt == FL_W'(FLUSH_CNT - 1)) begin
            tmo_cnt <= '0;
            state   <= S_WAIT;
          end
        end
`endif
        S_WAIT: begin
          if (pe_busy) seen_busy <= 1'b1;
          tmo_cnt <= tmo_cnt + TMO_W'(1);
          if (seen_busy && !pe_busy) begin
            res_data_q <= pe_mac_value;
            res_err_q  <= 1'b0;
            state      <= S_RES;
          end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
            res_data_q <= pe_mac_value;
            res_err_q  <= 1'b1;
            state      <= S_RES;
          end
        end
        S_RES: begin
          if (res_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign pe_cmd_valid    = cmd_vld_p1;
  assign pe_cmd          = cmd_p1;
  assign pe_param_1      = param_p1;
  assign pe_preload_data = preload_p1;
  assign pe_data         = data_p1;
  assign pe_weight       = weight_p1;
  assign res_valid       = (state == S_RES);
  assign res_data        = res_data_q;
  assign res_err         = res_err_q;

endmodule

// File: tb/tb_pe_cmd_seq.sv
`timescale 1ns/1ps
module tb_pe_cmd_seq;
  localparam int ACLEN = 8;
  localparam int DW    = 32;
  localparam int LW    = 16;
  localparam int TMO   = 64;
  localparam int FLC   = 4;
  localparam int CW    = ACLEN + 1;

  localparam logic [CW-1:0] C_RESET = CW'(0);
  localparam logic [CW-1:0] C_TRIG  = CW'(1);
  localparam logic [CW-1:0] C_LAST  = CW'(2);
  localparam logic [CW-1:0] C_LOAD  = CW'(5);
  localparam logic [CW-1:0] C_CONV  = CW'(6);
  localparam logic [CW-1:0] C_FWD   = CW'(8);

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          job_valid = 1'b0;
  logic          job_ready;
  logic [LW-1:0] job_len = '0;
  logic          job_preload = 1'b0;
  logic [DW-1:0] job_preload_val = '0;
  logic          op_valid = 1'b0;
  logic          op_ready;
  logic [DW-1:0] op_data = '0;
  logic [DW-1:0] op_weight = '0;
  logic          pe_cmd_valid;
  logic [CW-1:0] pe_cmd;
  logic [DW-1:0] pe_param_1, pe_preload_data, pe_data, pe_weight;
  logic          pe_busy = 1'b0;
  logic [DW-1:0] pe_mac_value = '0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [DW-1:0] res_data;
  logic          res_err;

  pe_cmd_seq #(.ACLEN(ACLEN), .DATA_WIDTH(DW), .LEN_WIDTH(LW), .TIMEOUT(TMO), .FLUSH_CNT(FLC)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .job_valid(job_valid), .job_ready(job_ready), .job_len(job_len),
    .job_preload(job_preload), .job_preload_val(job_preload_val),
    .op_valid(op_valid), .op_ready(op_ready), .op_data(op_data), .op_weight(op_weight),
    .pe_cmd_valid(pe_cmd_valid), .pe_cmd(pe_cmd), .pe_param_1(pe_param_1),
    .pe_preload_data(pe_preload_data), .pe_data(pe_data), .pe_weight(pe_weight),
    .pe_busy(pe_busy), .pe_mac_value(pe_mac_value),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_asrt = 0;
  int n_fail = 0;

  // Expected and observed command streams, operands of the current job.
  logic [CW-1:0] e_cmd[$], o_cmd[$];
  logic [DW-1:0] e_a[$], e_b[$], o_a[$], o_b[$];
  logic [DW-1:0] j_d[$], j_w[$];
  int            last_cmd_cyc = 0;

  // Directed operand values for the first job (1.0..6.0 as IEEE-754 bits).
  bit            dir_en = 1'b0;
  logic [DW-1:0] dir_d[3] = '{32'h3F800000, 32'h40400000, 32'h40A00000};
  logic [DW-1:0] dir_w[3] = '{32'h40000000, 32'h40800000, 32'h40C00000};

  // PE model: busy rises one cycle after the first trigger and falls a few
  // cycles after the K-th trigger; RESET clears it.
  int m_k = 0, m_trig = 0, m_fall = 0;
  bit m_en = 1'b1, m_rise = 1'b0;

  always @(negedge clk_i) begin
    logic [DW-1:0] a;
    if (m_rise) begin pe_busy = 1'b1; m_rise = 1'b0; end
    if (m_fall > 0) begin
      m_fall = m_fall - 1;
      if (m_fall == 0) pe_busy = 1'b0;
    end
    if (pe_cmd_valid) begin
      case (pe_cmd)
        C_CONV:  a = pe_param_1;
        C_LOAD:  a = pe_preload_data;
        default: a = pe_data;
      endcase
      o_cmd.push_back(pe_cmd);
      o_a.push_back(a);
      o_b.push_back(pe_weight);
      last_cmd_cyc = cyc;
      if (pe_cmd == C_RESET) begin
        m_trig = 0; m_rise = 1'b0; m_fall = 0; pe_busy = 1'b0;
      end else if (pe_cmd == C_TRIG || pe_cmd == C_LAST) begin
        m_trig = m_trig + 1;
        if (m_en) begin
          if (m_trig == 1) m_rise = 1'b1;
          if (m_trig == m_k) m_fall = $urandom_range(14, 6);
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [CW-1:0] c, input logic [DW-1:0] a, input logic [DW-1:0] b);
    e_cmd.push_back(c); e_a.push_back(a); e_b.push_back(b);
  endtask

  task automatic start_job(input int k, input bit pre, input logic [DW-1:0] pval,
                           input logic [DW-1:0] mac, input bit busy_on);
    logic [DW-1:0] d, w;
    @(negedge clk_i); #2;
    e_cmd.delete(); e_a.delete(); e_b.delete();
    o_cmd.delete(); o_a.delete(); o_b.delete();
    j_d.delete(); j_w.delete();
    push_exp(C_RESET, '0, '0);
    push_exp(C_CONV, DW'(k), '0);
    if (k > 0 && pre) push_exp(C_LOAD, pval, '0);
    for (int i = 0; i < k; i++) begin
      d = (dir_en && i < 3) ? dir_d[i] : DW'($urandom);
      w = (dir_en && i < 3) ? dir_w[i] : DW'($urandom);
      j_d.push_back(d); j_w.push_back(w);
      push_exp((i == k - 1 && k != 1) ? C_LAST : C_TRIG, d, w);
    end
`ifdef PE_CMD_SEQ_FORWARD_EN
    if (k > 0) for (int i = 0; i < FLC; i++) push_exp(C_FWD, '0, '0);
`endif
    m_k = k; m_en = busy_on; pe_mac_value = mac;
    job_valid = 1'b1; job_len = LW'(k); job_preload = pre; job_preload_val = pval;
    #1 chk("job_ready_idle", job_ready, 1);
    @(negedge clk_i);
    job_valid = 1'b0;
    #1 chk("job_ready_busy", job_ready, 0);
  endtask

  task automatic feed(input int n, input int glo, input int ghi, input bit final_chk);
    int gap, budget;
    bit acc;
    for (int i = 0; i < n; i++) begin
      gap = $urandom_range(ghi, glo);
      for (int g = 0; g < gap; g++) begin @(negedge clk_i); op_valid = 1'b0; end
      @(negedge clk_i);
      op_valid = 1'b1; op_data = j_d[i]; op_weight = j_w[i];
      acc = 1'b0; budget = 0;
      while (!acc) begin
        #1 acc = op_ready;
        @(posedge clk_i);
        if (!acc) begin
          budget++;
          if (budget > 500) begin chk("op_accept_timeout", 0, 1); op_valid = 1'b0; return; end
          @(negedge clk_i);
        end
      end
    end
    @(negedge clk_i);
    op_valid = 1'b0;
    if (final_chk) begin
      #1 chk("op_ready_after_last", op_ready, 0);
    end
  endtask

  task automatic finish_job(input logic [DW-1:0] exp_data, input bit exp_err, input int k,
                            input bit chk_tmo, input int hold);
    int n, rc;
    n = 0;
    while (!res_valid && n < TMO + 300) begin @(negedge clk_i); n++; end
    chk("res_valid_seen", res_valid, 1);
    if (!res_valid) return;
    rc = cyc;
    chk("res_data", res_data, exp_data);
    chk("res_err", res_err, exp_err);
    chk("job_ready_in_res", job_ready, 0);
    chk("param_1_hold", pe_param_1, DW'(k));
    if (chk_tmo) chk("timeout_latency", 64'(rc - last_cmd_cyc), TMO);
    for (int h = 0; h < hold; h++) begin
      if (h == 2) begin job_valid = 1'b1; job_len = LW'(5); end
      if (h == 4) job_valid = 1'b0;
      @(negedge clk_i);
      chk("res_valid_hold", res_valid, 1);
      chk("res_data_hold", res_data, exp_data);
      chk("job_ready_hold", job_ready, 0);
    end
    job_valid = 1'b0;
    res_ready = 1'b1;
    @(negedge clk_i);
    res_ready = 1'b0;
    #1 chk("res_valid_after_hs", res_valid, 0);
    chk("job_ready_after_hs", job_ready, 1);
    repeat (3) @(negedge clk_i);
    #2 chk("cmd_count", o_cmd.size(), e_cmd.size());
    for (int i = 0; i < o_cmd.size() && i < e_cmd.size(); i++) begin
      chk($sformatf("cmd[%0d]", i), o_cmd[i], e_cmd[i]);
      if (e_cmd[i] != C_RESET) chk($sformatf("cmd_a[%0d]", i), o_a[i], e_a[i]);
      if (e_cmd[i] == C_TRIG || e_cmd[i] == C_LAST || e_cmd[i] == C_FWD)
        chk($sformatf("cmd_b[%0d]", i), o_b[i], e_b[i]);
    end
  endtask

  task automatic run_job(input int k, input bit pre, input logic [DW-1:0] pval,
                         input logic [DW-1:0] mac, input int glo, input int ghi,
                         input bit busy_on, input int hold);
    start_job(k, pre, pval, mac, busy_on);
    if (k > 0) feed(k, glo, ghi, 1'b1);
    finish_job((k == 0) ? '0 : mac, !busy_on && k > 0, k, !busy_on && k > 0, hold);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst_i = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("rst_job_ready", job_ready, 1);
    chk("rst_op_ready", op_ready, 0);
    chk("rst_cmd_valid", pe_cmd_valid, 0);
    chk("rst_cmd", pe_cmd, 0);
    chk("rst_param_1", pe_param_1, 0);
    chk("rst_data", pe_data, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);

    // K=3 directed dot product, back-to-back operands.
    dir_en = 1'b1;
    run_job(3, 1'b0, '0, 32'h42300000, 0, 0, 1'b1, 0);
    dir_en = 1'b0;
    // K=2, preload 10.0, 5-cycle operand gaps.
    run_job(2, 1'b1, 32'h41200000, 32'h41F00000, 5, 5, 1'b1, 0);
    // K=1: single TRIGGER.
    run_job(1, 1'b0, '0, 32'h3F000000, 0, 2, 1'b1, 0);
    // Busy never rises: timeout completion.
    run_job(2, 1'b0, '0, 32'hCAFEF00D, 0, 1, 1'b0, 0);
    // Result back-pressure with a stray job request.
    run_job(3, 1'b1, 32'h12345678, 32'h0BADBEEF, 0, 2, 1'b1, 7);
    // K=0: CLR/CFG only, zero result.
    run_job(0, 1'b1, 32'h11111111, 32'hDEADBEEF, 0, 0, 1'b1, 0);

    // Reset in the middle of streaming.
    start_job(8, 1'b0, '0, 32'h55AA55AA, 1'b1);
    feed(4, 0, 0, 1'b0);
    #1;
    o_cmd.delete(); o_a.delete(); o_b.delete();
    op_valid = 1'b1;
    rst_i = 1'b0;
    #1;
    chk("mid_rst_cmd_valid", pe_cmd_valid, 0);
    chk("mid_rst_cmd", pe_cmd, 0);
    chk("mid_rst_data", pe_data, 0);
    chk("mid_rst_weight", pe_weight, 0);
    chk("mid_rst_param_1", pe_param_1, 0);
    chk("mid_rst_preload", pe_preload_data, 0);
    chk("mid_rst_op_ready", op_ready, 0);
    chk("mid_rst_job_ready", job_ready, 1);
    @(negedge clk_i);
    rst_i = 1'b1;
    repeat (10) @(negedge clk_i);
    #2 chk("no_cmd_after_rst", o_cmd.size(), 0);
    op_valid = 1'b0;
    run_job(2, 1'b0, '0, 32'h40490FDB, 0, 1, 1'b1, 0);

    // Randomized jobs.
    for (int j = 0; j < 6; j++) begin
      run_job($urandom_range(6, 1), 1'($urandom_range(1, 0)), DW'($urandom), DW'($urandom),
              0, 3, 1'b1, $urandom_range(2, 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/pe_cmd_seq.md
Name: pe_cmd_seq

Overview:
Command-issuing master for a single floating-point MAC PE. It accepts a dot-product job (length K, optional preload value) and drives the PE command bus with RESET, SET_CONV_MODE, optional LOAD_DATA, then K TRIGGER/TRIGGER_LAST beats fed from an operand stream. It then waits for the PE busy flag to clear and returns mac_value on a valid/ready result port. It sits between the tile scheduler and one PE; array controllers instantiate one per PE column.

Parameters:
ACLEN, 8, pe_cmd width is ACLEN+1
DATA_WIDTH, 32, operand/result width (IEEE-754 single)
LEN_WIDTH, 16, width of job_len
TIMEOUT, 1024, max WAIT cycles before error completion
FLUSH_CNT, 4, FORWARD beats issued when PE_CMD_SEQ_FORWARD_EN is defined

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-low
job_valid  in  1  job request
job_ready  out  1  high only in IDLE
job_len  in  LEN_WIDTH  K, number of MAC terms
job_preload  in  1  issue LOAD_DATA before streaming
job_preload_val  in  DATA_WIDTH  value for LOAD_DATA
op_valid  in  1  operand pair valid
op_ready  out  1  operand accepted this cycle
op_data  in  DATA_WIDTH  activation
op_weight  in  DATA_WIDTH  weight
pe_cmd_valid  out  1  command strobe (registered)
pe_cmd  out  ACLEN+1  command code
pe_param_1  out  DATA_WIDTH  param_1 to PE
pe_preload_data  out  DATA_WIDTH  preload to PE
pe_data  out  DATA_WIDTH  data_in to PE
pe_weight  out  DATA_WIDTH  weight_in to PE
pe_busy  in  1  PE busy flag
pe_mac_value  in  DATA_WIDTH  PE accumulator
res_valid  out  1  result valid
res_ready  in  1  result accepted
res_data  out  DATA_WIDTH  captured mac_value
res_err  out  1  timeout flag, valid with res_valid

Behaviour:
- Command codes: RESET=0, TRIGGER=1, TRIGGER_LAST=2, LOAD_DATA=5, SET_CONV_MODE=6, FORWARD=8.
- Reset: state IDLE. All outputs 0 except job_ready=1. Counters and sticky flags cleared.
- Reset asserted mid-job aborts immediately. No command is issued after reset releases until a new job is accepted.
- All pe_* outputs are registered.
  - pe_cmd_valid is high for exactly one cycle per command.
  - pe_data, pe_weight, pe_param_1 and pe_preload_data hold their last value while pe_cmd_valid=0.
- States:
  - IDLE: on job_valid, latch the job fields and go to CLR.
  - CLR: issue RESET for 1 cycle, go to CFG.
  - CFG: issue SET_CONV_MODE with pe_param_1=K. Go to PRE if the preload flag is set, else STRM.
  - PRE: issue LOAD_DATA with pe_preload_data=preload_val, go to STRM.
  - STRM: op_ready=1 while beat count < K. Each accepted pair is issued the next cycle.
    - Beats 0..K-2 use TRIGGER; beat K-1 uses TRIGGER_LAST.
    - Exception: K=1 issues a single TRIGGER, so PE busy asserts.
    - Cycles with op_valid=0 issue no command. Gaps are legal and unbounded.
    - After the cycle issuing the final beat, go to FLSH if the feature is enabled, else WAIT.
  - WAIT: set a sticky seen_busy flag while pe_busy=1. A free-running timeout counter starts at 0.
    - When seen_busy=1 and pe_busy=0: capture pe_mac_value, res_err=0, go to RES.
    - If the counter reaches TIMEOUT-1 first: capture pe_mac_value, res_err=1, go to RES.
  - RES: res_valid=1; res_data and res_err stay stable until res_ready. On handshake go to IDLE (job_ready=1 the next cycle).
- K=0: CLR and CFG are issued, PRE/STRM/WAIT are skipped. Go to RES with res_data=0, res_err=0.
- seen_busy is also set by pe_busy observed during STRM, because busy rises one cycle after the first TRIGGER.
- A job_valid presented outside IDLE is ignored (job_ready=0).
- Beat counter is LEN_WIDTH bits. K=2^LEN_WIDTH-1 must complete without wrap.

Optional Feature:
PE_CMD_SEQ_FORWARD_EN
- Defined: after the final TRIGGER/TRIGGER_LAST, state FLSH issues FLUSH_CNT consecutive FORWARD commands with pe_data=pe_weight=0. This drains downstream PEs in a chain. WAIT then begins.
- Undefined: FLSH does not exist and STRM goes directly to WAIT; no FORWARD code is ever emitted.

Test Plan:
- K=3, no preload, ops (1.0,2.0),(3.0,4.0),(5.0,6.0) back-to-back; model busy high 2..20 cycles after first TRIGGER and mac=44.0 -> cmd sequence 0,6(param_1=3),1,1,2; res_data=0x42300000, res_err=0.
- K=2, preload 10.0, op_valid gapped 5 cycles between beats -> cmds 0,6,5(preload 0x41200000),1,2; no pe_cmd_valid during gap; op_ready drops after 2nd beat.
- K=1 -> single TRIGGER (code 1), never TRIGGER_LAST; completes when busy falls.
- pe_busy held 0 forever, K=2 -> res_err=1 exactly TIMEOUT cycles after WAIT entry; res_data=pe_mac_value at that cycle.
- res_ready held low 7 cycles -> res_valid/res_data stable; job_ready stays 0; second job_valid ignored until handshake.
- rst_i low for 1 cycle mid-STRM (K=8, beat 4) -> outputs 0 asynchronously; no further commands; a new K=2 job then runs cleanly. With PE_CMD_SEQ_FORWARD_EN, 4 FORWARD commands follow TRIGGER_LAST.
